memory_dma: RTL and testbench

MEMORY_DMA -- requirements
Module: memory_dma

---
 rtl/memory_dma.sv | 190 +++++++++++++++++++
 tb/tb_memory_dma.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_dma.sv
// memory_dma: single-channel word-copy engine. Reads one 32-bit word from the
// source address, writes it to the destination address, and repeats for
// word_count words. At most one memory request is in flight at any time.

package memory_io_pkg;

  // Request from the DMA to the memory responder.
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  do_read;
    logic [3:0]  do_write;
  } memory_io_req;

  // Response from the memory responder to the DMA.
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
  } memory_io_rsp;

  localparam memory_io_req MEMORY_IO_NO_REQ = '0;

endpackage

module memory_dma
  import memory_io_pkg::*;
#(
  parameter int CNT_W                 = 16,
  parameter bit ENABLE_RSP_ADDR_CHECK = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [CNT_W-1:0] word_count,
  output logic             busy,
  output logic             done,
  output logic             err,
  output memory_io_req     mem_req,
  input  memory_io_rsp     mem_rsp
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [31:0] WORD_BYTES = 32'd4;
  localparam logic [3:0]  ALL_LANES  = 4'b1111;

  state_t           state;
  state_t           state_next;
  logic [31:0]      cur_src;
  logic [31:0]      cur_dst;
  logic [CNT_W-1:0] remaining;
  logic [31:0]      hold_data;
  logic             err_q;

  // Word addressing only: the two low address bits are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{src_addr[1:0], dst_addr[1:0]};

  // The word being finished in WR_WAIT is the last one when one word remains.
  logic last_word;
  assign last_word = (remaining == CNT_W'(1));

  // Address a response must carry: the address of the request it answers.
  // The address registers do not move while waiting, so no copy is kept.
  logic [31:0] outstanding_addr;
  assign outstanding_addr = (state == WR_WAIT) ? cur_dst : cur_src;

  logic rsp_addr_bad;
  assign rsp_addr_bad = ENABLE_RSP_ADDR_CHECK && (mem_rsp.addr != outstanding_addr);

  // State register.
  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values of its inputs, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: one request per REQ state, WAIT states hold for a response.
  // NOTE: state_next gets a default before the case so every path assigns it
  // and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (word_count == '0) ? DONE : RD_REQ;
        end
      end
      RD_REQ:  state_next = RD_WAIT;
      RD_WAIT: begin
        if (mem_rsp.valid) begin
          state_next = WR_REQ;
        end
      end
      WR_REQ:  state_next = WR_WAIT;
      WR_WAIT: begin
        if (mem_rsp.valid) begin
          state_next = last_word ? DONE : RD_REQ;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: command capture, read-data holding, address/count stepping, err flag.
  // NOTE: the holding register is a single flop word, not a memory array, so
  // it is cleared by reset along with the address and count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_src   <= '0;
      cur_dst   <= '0;
      remaining <= '0;
      hold_data <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cur_src   <= {src_addr[31:2], 2'b00};
            cur_dst   <= {dst_addr[31:2], 2'b00};
            remaining <= word_count;
            err_q     <= 1'b0;
          end
        end
        RD_WAIT: begin
          if (mem_rsp.valid) begin
            hold_data <= mem_rsp.data;
            if (rsp_addr_bad) begin
              err_q <= 1'b1;
            end
          end
        end
        WR_WAIT: begin
          if (mem_rsp.valid) begin
            // Plain 32-bit adds: address wrap past 0xFFFFFFFC is intended.
            cur_src   <= cur_src + WORD_BYTES;
            cur_dst   <= cur_dst + WORD_BYTES;
            remaining <= remaining - CNT_W'(1);
            if (rsp_addr_bad) begin
              err_q <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Memory request decode: only the two REQ states drive a valid request.
  always_comb begin
    mem_req = MEMORY_IO_NO_REQ;
    case (state)
      RD_REQ: begin
        mem_req.valid   = 1'b1;
        mem_req.addr    = cur_src;
        mem_req.do_read = ALL_LANES;
      end
      WR_REQ: begin
        mem_req.valid    = 1'b1;
        mem_req.addr     = cur_dst;
        mem_req.data     = hold_data;
        mem_req.do_write = ALL_LANES;
      end
      default: begin
      end
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign err  = err_q;

endmodule

// File: tb/tb_memory_dma.sv
// tb_memory_dma: table-driven copies against a behavioural memory responder
// with programmable stall, plus hand sequences for reset and address-check cases.
// Expected requests are queued when a copy is set up and compared as the DUT
// issues them.

module tb_memory_dma;
  import memory_io_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [31:0]  src_addr;
  logic [31:0]  dst_addr;
  logic [15:0]  word_count;
  logic         busy;
  logic         done;
  logic         err;
  memory_io_req mem_req;
  memory_io_rsp mem_rsp;

  memory_dma #(
    .CNT_W                 (16),
    .ENABLE_RSP_ADDR_CHECK (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .mem_req    (mem_req),
    .mem_rsp    (mem_rsp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Expected request stream (scoreboard) and expected destination contents.
  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
  } exp_req_t;

  exp_req_t    sb[$];
  exp_req_t    dst_exp[$];
  logic [31:0] mem [logic [31:0]];

  // Responder controls.
  int stall_cycles = 0;
  int corrupt_at   = -1;
  int rsp_count    = 0;
  int req_seen     = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // Memory responder: takes a request mid-cycle, answers stall_cycles+1
  // cycles later, and checks each request against the scoreboard.
  initial begin : responder
    logic     pending;
    int       wait_left;
    exp_req_t cur;
    exp_req_t e;
    pending = 1'b0;
    wait_left = 0;
    mem_rsp = '0;
    forever begin
      @(negedge clk);
      mem_rsp = '0;
      if (mem_req.valid) begin
        req_seen++;
        check("one_outstanding", {31'd0, pending}, 32'd0);
        cur.addr = mem_req.addr;
        cur.wr   = (mem_req.do_write != 4'h0);
        cur.data = mem_req.data;
        if (sb.size() == 0) begin
          check("unexpected_req", mem_req.addr, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("req_addr", mem_req.addr, e.addr);
          check("req_do_read", {28'd0, mem_req.do_read}, e.wr ? 32'h0 : 32'hF);
          check("req_do_write", {28'd0, mem_req.do_write}, e.wr ? 32'hF : 32'h0);
          check("req_data", mem_req.data, e.wr ? e.data : 32'h0);
        end
        pending = 1'b1;
        wait_left = stall_cycles;
      end else if (pending) begin
        if (wait_left == 0) begin
          mem_rsp.valid = 1'b1;
          mem_rsp.addr  = cur.addr;
          if (cur.wr) begin
            mem[cur.addr] = cur.data;
          end else begin
            mem_rsp.data = mem_rd(cur.addr);
          end
          if (rsp_count == corrupt_at) begin
            mem_rsp.addr = cur.addr ^ 32'h0000_0010;
          end
          rsp_count++;
          pending = 1'b0;
        end else begin
          wait_left--;
        end
      end
    end
  end

  // Preload source words and queue the request stream the copy must produce.
  task automatic prep_copy(input logic [31:0] src, input logic [31:0] dst,
                           input int n, input logic [31:0] first_word);
    logic [31:0] s;
    logic [31:0] d;
    logic [31:0] w;
    exp_req_t    r;
    s = {src[31:2], 2'b00};
    d = {dst[31:2], 2'b00};
    for (int i = 0; i < n; i++) begin
      w = (i == 0) ? first_word : $urandom;
      mem[s] = w;
      r.addr = s; r.wr = 1'b0; r.data = 32'h0;
      sb.push_back(r);
      r.addr = d; r.wr = 1'b1; r.data = w;
      sb.push_back(r);
      dst_exp.push_back(r);
      s = s + 32'd4;
      d = d + 32'd4;
    end
  endtask

  task automatic launch(input logic [31:0] src, input logic [31:0] dst, input int n);
    @(negedge clk);
    start      = 1'b1;
    src_addr   = src;
    dst_addr   = dst;
    word_count = n[15:0];
  endtask

  // One full copy: launch, count cycles to done, then check memory and flags.
  task automatic run_copy(input string tag, input logic [31:0] src, input logic [31:0] dst,
                          input int n, input int stall, input int exp_cycles,
                          input logic [31:0] first_word, input logic exp_err);
    int   n_cyc;
    int   busy_cyc;
    logic got;
    exp_req_t r;
    stall_cycles = stall;
    dst_exp.delete();
    prep_copy(src, dst, n, first_word);
    launch(src, dst, n);
    n_cyc = 0;
    busy_cyc = 0;
    got = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk);
      start = 1'b0;
      n_cyc++;
      if (c == 0) check({tag, " err_cleared_on_start"}, {31'd0, err}, 32'd0);
      if (busy) busy_cyc++;
      if (done) got = 1'b1;
    end
    check({tag, " done_seen"}, {31'd0, got}, 32'd1);
    check({tag, " cycles"}, n_cyc, exp_cycles);
    check({tag, " busy_cycles"}, busy_cyc, exp_cycles);
    check({tag, " err"}, {31'd0, err}, {31'd0, exp_err});
    @(negedge clk);
    check({tag, " idle_after_done"}, {30'd0, busy, done}, 32'd0);
    check({tag, " sb_empty"}, sb.size(), 32'd0);
    while (dst_exp.size() > 0) begin
      r = dst_exp.pop_front();
      check({tag, " dst_word"}, mem_rd(r.addr), r.data);
    end
  endtask

  typedef struct {
    string       tag;
    logic [31:0] src;
    logic [31:0] dst;
    int          n;
    int          stall;
    int          cycles;
    logic [31:0] first_word;
  } vec_t;

  vec_t vecs[5];

  initial begin : main
    int dones;
    int base;
    logic hit;

    vecs[0] = '{"single",  32'h0000_0100, 32'h0000_0200, 1, 0, 5,  32'hDEAD_BEEF};
    vecs[1] = '{"unalign", 32'h0000_0103, 32'h0000_0302, 4, 0, 17, 32'h1234_5678};
    vecs[2] = '{"zero",    32'h0000_0400, 32'h0000_0500, 0, 0, 1,  32'h0};
    vecs[3] = '{"stall3",  32'h0000_0600, 32'h0000_0700, 2, 3, 21, 32'hCAFE_F00D};
    vecs[4] = '{"stall1",  32'h0000_1000, 32'h0000_2000, 3, 1, 19, 32'h0BAD_CAFE};

    reset = 1'b1;
    start = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    word_count = '0;
    repeat (3) @(negedge clk);
    check("reset busy/done/err", {29'd0, busy, done, err}, 32'd0);
    check("reset mem_req_valid", {31'd0, mem_req.valid}, 32'd0);
    check("reset mem_req_addr", mem_req.addr, 32'd0);
    reset = 1'b0;

    for (int v = 0; v < 5; v++) begin
      run_copy(vecs[v].tag, vecs[v].src, vecs[v].dst, vecs[v].n, vecs[v].stall,
               vecs[v].cycles, vecs[v].first_word, 1'b0);
    end
    check("single dst_0x200", mem_rd(32'h0000_0200), 32'hDEAD_BEEF);

    // Reset wins over a start in the same cycle.
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    src_addr = 32'h0000_0800;
    dst_addr = 32'h0000_0900;
    word_count = 16'd3;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check("rst_vs_start busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("rst_vs_start still_idle", {31'd0, busy | mem_req.valid}, 32'd0);

    // Reset during WR_WAIT of word 2 of 4 abandons the copy.
    stall_cycles = 3;
    dst_exp.delete();
    prep_copy(32'h0000_3000, 32'h0000_4000, 4, 32'h5555_AAAA);
    base = req_seen;
    launch(32'h0000_3000, 32'h0000_4000, 4);
    hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (req_seen >= base + 4) hit = 1'b1;
    end
    check("midrst reached_wr2", {31'd0, hit}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    dst_exp.delete();
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst req_valid", {31'd0, mem_req.valid}, 32'd0);
    check("midrst done", {31'd0, done}, 32'd0);
    dones = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    check("midrst no_activity", dones, 32'd0);
    run_copy("after_rst", 32'h0000_3000, 32'h0000_4000, 4, 0, 17, 32'h7777_1111, 1'b0);

    // Source wraps past 0xFFFFFFFC; a corrupted response address sets sticky err.
    corrupt_at = rsp_count;
    run_copy("wrap_err", 32'hFFFF_FFFC, 32'h0000_5000, 2, 0, 9, 32'h0F0F_0F0F, 1'b1);
    corrupt_at = -1;
    repeat (3) @(negedge clk);
    check("err sticky", {31'd0, err}, 32'd1);
    run_copy("err_clear", 32'h0000_6000, 32'h0000_7000, 1, 0, 5, 32'hA5A5_5A5A, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
